// File: rtl/source_line_feeder.sv
// Normalises the source byte stream into one buffered line, then replays it as new_line + one strobe per char.
// Line emission starts one cycle after its terminator is accepted; byte_ready_out stays low outside FILL.
module source_line_feeder #(
   parameter int CHAR_PER_LINE = 64,
   parameter int LINE_W        = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              byte_valid_in,
   input  logic [7:0]        byte_in,
   output logic              byte_ready_out,
   output logic              new_line,
   output logic              new_character,
   output logic [7:0]        incoming_character,
   input  logic              inst_done_in,
   input  logic              inst_error_in,
   output logic [LINE_W-1:0] line_num_out,
   output logic              overflow_out,
   output logic              error_seen_out,
   output logic [LINE_W-1:0] error_line_out,
   output logic              finished_out
);
   localparam int LEN_W = $clog2(CHAR_PER_LINE + 1);
   localparam int IDX_W = (CHAR_PER_LINE > 1) ? $clog2(CHAR_PER_LINE) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(CHAR_PER_LINE);

   typedef enum logic [2:0] {FILL, START, EMIT, WAIT, DONE} state_t;
   state_t state, state_nxt;

   logic [7:0]        line_buf [CHAR_PER_LINE];
   logic [LEN_W-1:0]  len, idx, ch_pos;
   logic              comment, pending, ovf, eot, running;
   logic [LINE_W-1:0] line_cnt, line_num, err_line;
   logic              err_seen, ovf_pulse;
   logic [7:0]        ch;
   logic              take, is_term, term, emit_go, char_in, room1, room2;
   logic              wr_sp, wr_ch, set_ovf, last;

   assign take    = byte_ready_out & byte_valid_in;
   assign is_term = (byte_in == 8'h0A) || (byte_in == 8'h04);
   assign term    = take && is_term;
   assign emit_go = term && !ovf && (len != '0);
   assign ch      = (byte_in == 8'h09) ? 8'h20 :
                    ((byte_in >= 8'h41) && (byte_in <= 8'h5A)) ? byte_in + 8'h20 : byte_in;
   assign last    = (idx == len - LEN_W'(1));

   // A deferred space and the character that releases it land in the same cycle.
   assign char_in = take && !is_term && (byte_in != 8'h0D) && !comment &&
                    (ch != 8'h23) && (ch != 8'h20) && !ovf;
   assign room1   = (len < LEN_MAX);
   assign room2   = (len < LEN_MAX - LEN_W'(1));
   assign wr_sp   = char_in && pending && room1;
   assign wr_ch   = char_in && (pending ? room2 : room1);
   assign set_ovf = char_in && !wr_ch;
   assign ch_pos  = pending ? len + LEN_W'(1) : len;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= FILL;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      byte_ready_out = 1'b0;
      new_line       = 1'b0;
      new_character  = 1'b0;
      finished_out   = 1'b0;
      case (state)
         FILL: begin
            byte_ready_out = running;
            if (emit_go)                         state_nxt = START;
            else if (term && byte_in == 8'h04)   state_nxt = DONE;
         end
         START: begin
            new_line  = 1'b1;
            state_nxt = EMIT;
         end
         EMIT: begin
            new_character = 1'b1;
            if (last) state_nxt = WAIT;
         end
         WAIT: begin
            if (inst_done_in || inst_error_in) state_nxt = eot ? DONE : FILL;
         end
         DONE:    finished_out = 1'b1;
         default: state_nxt = FILL;
      endcase
   end

   assign incoming_character = new_character ? line_buf[idx[IDX_W-1:0]] : 8'h00;

   always_ff @(posedge clk_in) begin
      if (wr_sp) line_buf[len[IDX_W-1:0]]    <= 8'h20;
      if (wr_ch) line_buf[ch_pos[IDX_W-1:0]] <= ch;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         len       <= '0;
         idx       <= '0;
         comment   <= 1'b0;
         pending   <= 1'b0;
         ovf       <= 1'b0;
         eot       <= 1'b0;
         running   <= 1'b0;
         line_cnt  <= LINE_W'(1);
         line_num  <= '0;
         err_seen  <= 1'b0;
         err_line  <= '0;
         ovf_pulse <= 1'b0;
      end else begin
         running   <= 1'b1;
         ovf_pulse <= 1'b0;
         if (take && is_term) begin
            comment <= 1'b0;
            pending <= 1'b0;
            ovf     <= 1'b0;
            if (byte_in == 8'h0A && line_cnt != '1) line_cnt <= line_cnt + LINE_W'(1);
            if (byte_in == 8'h04) eot <= 1'b1;
            if (ovf) begin
               ovf_pulse <= 1'b1;
               len       <= '0;
               err_seen  <= 1'b1;
               if (!err_seen) err_line <= line_cnt;
            end else if (len != '0) begin
               line_num <= line_cnt;
            end
         end else if (take) begin
            if (byte_in != 8'h0D && !comment) begin
               if (ch == 8'h23)      comment <= 1'b1;
               else if (ch == 8'h20) begin
                  if (len != '0) pending <= 1'b1;
               end else              pending <= 1'b0;
            end
            len <= len + LEN_W'(wr_sp) + LEN_W'(wr_ch);
            ovf <= ovf | set_ovf;
         end
         if (state == START) idx <= '0;
         if (state == EMIT)  idx <= idx + LEN_W'(1);
         if (state == WAIT && (inst_done_in || inst_error_in)) begin
            len <= '0;
            if (inst_error_in) begin
               err_seen <= 1'b1;
               if (!err_seen) err_line <= line_num;
            end
         end
      end
   end

   assign line_num_out   = line_num;
   assign overflow_out   = ovf_pulse;
   assign error_seen_out = err_seen;
   assign error_line_out = err_line;
endmodule

// File: tb/tb_source_line_feeder.sv
// Directed bench for source_line_feeder: normalisation, blank/comment drop, overflow, error latch, EOT, mid-line reset.
module tb_source_line_feeder;
   localparam int CPL = 64;
   localparam int LW  = 16;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          byte_valid_in = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          inst_done_in = 1'b0;
   logic          inst_error_in = 1'b0;
   logic          byte_ready_out, new_line, new_character;
   logic [7:0]    incoming_character;
   logic [LW-1:0] line_num_out, error_line_out;
   logic          overflow_out, error_seen_out, finished_out;

   source_line_feeder #(.CHAR_PER_LINE(CPL), .LINE_W(LW)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .byte_valid_in(byte_valid_in), .byte_in(byte_in), .byte_ready_out(byte_ready_out),
      .new_line(new_line), .new_character(new_character), .incoming_character(incoming_character),
      .inst_done_in(inst_done_in), .inst_error_in(inst_error_in),
      .line_num_out(line_num_out), .overflow_out(overflow_out),
      .error_seen_out(error_seen_out), .error_line_out(error_line_out),
      .finished_out(finished_out)
   );

   always #5 clk_in = ~clk_in;

   int compared = 0;
   int mismatched = 0;

   int            cyc = 0;
   int            ovf_cnt = 0;
   logic [LW-1:0] nl_q[$];
   int            nl_cyc_q[$];
   logic [7:0]    ch_q[$];
   int            ch_cyc_q[$];
   int            nl_base = 0, ch_base = 0, ovf_base = 0;

   always @(negedge clk_in) begin
      cyc++;
      if (new_line) begin
         nl_q.push_back(line_num_out);
         nl_cyc_q.push_back(cyc);
      end
      if (new_character) begin
         ch_q.push_back(incoming_character);
         ch_cyc_q.push_back(cyc);
      end
      if (overflow_out) ovf_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      nl_base  = nl_q.size();
      ch_base  = ch_q.size();
      ovf_base = ovf_cnt;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_valid_in = 1'b1;
      byte_in       = b;
      while (!byte_ready_out && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 200) check("send_timeout", {31'd0, byte_ready_out}, 32'd1);
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      byte_in       = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_chars(input int n);
      int t;
      t = 0;
      while ((ch_q.size() - ch_base) < n && t < 500) begin
         @(negedge clk_in);
         t++;
      end
      repeat (2) @(negedge clk_in);
   endtask

   task automatic check_line(input string tag, input string exp, input int num);
      bit ok;
      check({tag, "_nl_count"}, nl_q.size() - nl_base, 1);
      check({tag, "_line_num"}, nl_q.size() > nl_base ? {16'd0, nl_q[nl_base]} : 32'hFFFF_FFFF, num);
      check({tag, "_len"}, ch_q.size() - ch_base, exp.len());
      ok = 1'b1;
      for (int i = 0; i < exp.len(); i++)
         if (ch_base + i >= ch_q.size() || ch_q[ch_base + i] != exp[i]) ok = 1'b0;
      check({tag, "_text"}, {31'd0, ok}, 32'd1);
      if (nl_q.size() > nl_base && ch_q.size() >= ch_base + exp.len() && exp.len() > 0) begin
         check({tag, "_first_cyc"}, ch_cyc_q[ch_base], nl_cyc_q[nl_base] + 1);
         check({tag, "_last_cyc"}, ch_cyc_q[ch_base + exp.len() - 1], nl_cyc_q[nl_base] + exp.len());
      end
   endtask

   task automatic decoder_reply(input logic err, input logic done);
      inst_error_in = err;
      inst_done_in  = done;
      @(negedge clk_in);
      inst_error_in = 1'b0;
      inst_done_in  = 1'b0;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      mark();
      @(negedge clk_in);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_ready", {31'd0, byte_ready_out}, 0);
      check("rst_new_line", {31'd0, new_line}, 0);
      check("rst_new_char", {31'd0, new_character}, 0);
      check("rst_char", {24'd0, incoming_character}, 0);
      check("rst_line_num", {16'd0, line_num_out}, 0);
      check("rst_err_seen", {31'd0, error_seen_out}, 0);
      check("rst_err_line", {16'd0, error_line_out}, 0);
      check("rst_finished", {31'd0, finished_out}, 0);
      check("rst_overflow", {31'd0, overflow_out}, 0);

      // Basic line with leading/trailing spaces, case and comment
      do_reset();
      check("ready_after_rst", {31'd0, byte_ready_out}, 1);
      send_str("  ADDI x1, x0, 5   # c\n");
      wait_chars(14);
      check_line("addi", "addi x1, x0, 5", 1);
      check("wait_ready", {31'd0, byte_ready_out}, 0);
      repeat (3) @(negedge clk_in);
      check("wait_hold_ready", {31'd0, byte_ready_out}, 0);
      check("wait_hold_nochar", ch_q.size() - ch_base, 14);
      decoder_reply(1'b0, 1'b1);
      check("ready_after_done", {31'd0, byte_ready_out}, 1);
      check("no_err_after_done", {31'd0, error_seen_out}, 0);

      // Blank and comment-only lines dropped, tab leading space, CR ignored
      do_reset();
      send_str("\n# only\r\n\tnop\n");
      wait_chars(3);
      check_line("nop", "nop", 3);
      decoder_reply(1'b0, 1'b1);

      // Overflow
      do_reset();
      for (int i = 0; i < 70; i++) send_byte(8'h61);
      send_byte(8'h0A);
      repeat (3) @(negedge clk_in);
      check("ovf_pulses", ovf_cnt - ovf_base, 1);
      check("ovf_no_new_line", nl_q.size() - nl_base, 0);
      check("ovf_err_seen", {31'd0, error_seen_out}, 1);
      check("ovf_err_line", {16'd0, error_line_out}, 1);
      check("ovf_ready", {31'd0, byte_ready_out}, 1);

      // Error wins over done; first error line sticks
      do_reset();
      send_str("nop\n");
      wait_chars(3);
      decoder_reply(1'b0, 1'b1);
      check("l1_no_err", {31'd0, error_seen_out}, 0);
      mark();
      send_str("ret\n");
      wait_chars(3);
      check_line("l2", "ret", 2);
      decoder_reply(1'b1, 1'b1);
      check("l2_err_seen", {31'd0, error_seen_out}, 1);
      check("l2_err_line", {16'd0, error_line_out}, 2);
      check("l2_ready", {31'd0, byte_ready_out}, 1);
      mark();
      send_str("nop\n");
      wait_chars(3);
      check_line("l3", "nop", 3);
      decoder_reply(1'b1, 1'b0);
      check("l3_err_line", {16'd0, error_line_out}, 2);

      // EOT without newline
      do_reset();
      send_str("ret");
      send_byte(8'h04);
      wait_chars(3);
      check_line("eot", "ret", 1);
      check("eot_not_finished", {31'd0, finished_out}, 0);
      decoder_reply(1'b0, 1'b1);
      check("eot_finished", {31'd0, finished_out}, 1);
      check("eot_ready", {31'd0, byte_ready_out}, 0);
      repeat (5) @(negedge clk_in);
      check("eot_ready_hold", {31'd0, byte_ready_out}, 0);
      check("eot_finished_hold", {31'd0, finished_out}, 1);
      check("eot_no_more_chars", ch_q.size() - ch_base, 3);

      // Reset mid-EMIT
      do_reset();
      send_str("lui x5, 1\n");
      begin
         int t;
         t = 0;
         while ((ch_q.size() - ch_base) < 3 && t < 200) begin
            @(negedge clk_in);
            t++;
         end
      end
      check("mid_emit_active", {31'd0, new_character}, 1);
      rst_in = 1'b0;
      #1;
      check("arst_new_char", {31'd0, new_character}, 0);
      check("arst_char", {24'd0, incoming_character}, 0);
      check("arst_ready", {31'd0, byte_ready_out}, 0);
      check("arst_line_num", {16'd0, line_num_out}, 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      mark();
      @(negedge clk_in);
      check("post_rst_no_strobe", {31'd0, new_character}, 0);
      repeat (3) @(negedge clk_in);
      check("post_rst_no_chars", ch_q.size() - ch_base, 0);
      send_str("nop\n");
      wait_chars(3);
      check_line("post_rst", "nop", 1);
      decoder_reply(1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
